// File: rtl/math_pkg.sv
// Shared constants and sizing helpers for the doublet math library sequential units.
package math_pkg;

    localparam logic [1:0] ADDN_IDLE = 2'd0;
    localparam logic [1:0] ADDN_RUN  = 2'd1;
    localparam logic [1:0] ADDN_DONE = 2'd2;

    function automatic int addn_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-slice build still needs a 1-bit index register.
    function automatic int addn_idx_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit adder slice; exposes the carry into its MSB for overflow detection.
module add_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_s,
    output logic             o_cout,
    output logic             o_cmsb
);

    logic [CHUNK:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
    assign o_s    = w_full[CHUNK-1:0];
    assign o_cout = w_full[CHUNK];
    // Sum bit = a ^ b ^ cin, so the carry into the MSB is recovered from the MSB sum bit.
    assign o_cmsb = i_a[CHUNK-1] ^ i_b[CHUNK-1] ^ w_full[CHUNK-1];

endmodule

// File: rtl/addn_seq.sv
// Multi-cycle WIDTH-bit add/subtract using one CHUNK-bit slice adder per clock.
// Optional saturation on signed overflow is enabled by defining ADDN_SEQ_SAT_EN.
module addn_seq
    import math_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
`ifdef ADDN_SEQ_SAT_EN
    input  logic             sat,
`endif
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int NCHUNK = addn_nchunk(WIDTH, CHUNK);
    localparam int IDXW   = addn_idx_w(NCHUNK);

    if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_width
        $fatal(1, "addn_seq: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_ovf;
`ifdef ADDN_SEQ_SAT_EN
    logic             r_sat;
`endif

    logic [CHUNK-1:0] w_a_sl;
    logic [CHUNK-1:0] w_b_sl;
    logic [CHUNK-1:0] w_s_sl;
    logic             w_cout;
    logic             w_cmsb;
    logic             w_last;
    logic             w_ovf;
    logic [WIDTH-1:0] w_sum_next;

    add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
        .i_a    (w_a_sl),
        .i_b    (w_b_sl),
        .i_cin  (r_c),
        .o_s    (w_s_sl),
        .o_cout (w_cout),
        .o_cmsb (w_cmsb)
    );

    always_comb begin
        w_a_sl     = r_a[int'(r_idx) * CHUNK +: CHUNK];
        w_b_sl     = r_b[int'(r_idx) * CHUNK +: CHUNK];
        w_last     = (r_idx == IDXW'(NCHUNK - 1));
        w_ovf      = w_cout ^ w_cmsb;
        w_sum_next = r_sum;
        w_sum_next[int'(r_idx) * CHUNK +: CHUNK] = w_s_sl;
`ifdef ADDN_SEQ_SAT_EN
        // On overflow the true result shares the sign of in1 (operands had equal effective signs).
        if (w_last && r_sat && w_ovf) begin
            w_sum_next = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ADDN_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
`ifdef ADDN_SEQ_SAT_EN
            r_sat   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ADDN_IDLE, ADDN_DONE: begin
                    if (start) begin
                        r_a     <= in1;
                        r_b     <= sub ? ~in2 : in2;
                        r_c     <= sub;
                        r_idx   <= '0;
                        r_sum   <= '0;
`ifdef ADDN_SEQ_SAT_EN
                        r_sat   <= sat;
`endif
                        r_state <= ADDN_RUN;
                    end else begin
                        r_state <= ADDN_IDLE;
                    end
                end
                ADDN_RUN: begin
                    r_sum <= w_sum_next;
                    r_c   <= w_cout;
                    if (w_last) begin
                        r_carry <= w_cout;
                        r_ovf   <= w_ovf;
                        r_state <= ADDN_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: r_state <= ADDN_IDLE;
            endcase
        end
    end

    assign busy     = (r_state == ADDN_RUN);
    assign done     = (r_state == ADDN_DONE);
    assign sum      = r_sum;
    assign carry    = r_carry;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_addn_seq.sv
// Self-checking bench for addn_seq (WIDTH=16, CHUNK=4) against an arithmetic reference model.
module tb_addn_seq;

    localparam int W = 16;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          sub = 1'b0;
    logic          sat = 1'b0;
    logic [W-1:0]  in1 = '0;
    logic [W-1:0]  in2 = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  sum;
    logic          carry;
    logic          overflow;

    int            checks = 0;
    int            errors = 0;
    int unsigned   ecnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    addn_seq #(.WIDTH(W), .CHUNK(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
`ifdef ADDN_SEQ_SAT_EN
        .sat      (sat),
`endif
        .in1      (in1),
        .in2      (in2),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carry    (carry),
        .overflow (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic straight from the operation rules.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  input logic st, output logic [W-1:0] r, output logic c,
                                  output logic o);
        int          sa;
        int          sb;
        int          t;
        int unsigned u;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            t = sa - sb;
            u = 32'(a) - 32'(b);
            c = (a >= b);
        end else begin
            t = sa + sb;
            u = 32'(a) + 32'(b);
            c = (u > 32'd65535);
        end
        r = u[W-1:0];
        o = (t > 32767) || (t < -32768);
        if (st && o) r = (t > 0) ? 16'h7FFF : 16'h8000;
    endfunction

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic st, input logic mid_pulse, output int unsigned done_edge);
        logic [W-1:0] er;
        logic         ec;
        logic         eo;
        logic         st_eff;
        int           lat;
        int           nb;
`ifdef ADDN_SEQ_SAT_EN
        st_eff = st;
`else
        st_eff = 1'b0;
`endif
        model(a, b, s, st_eff, er, ec, eo);
        @(negedge clk);
        in1 = a; in2 = b; sub = s; sat = st; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in1 = W'($urandom); in2 = W'($urandom); sub = ~s; sat = ~st;
        lat = 0;
        nb  = 0;
        while (!done && lat < 20) begin
            if (busy) nb++;
            if (mid_pulse && lat == 1) begin
                start = 1'b1; in1 = 16'd1; in2 = 16'd1; sub = 1'b0;
            end
            if (mid_pulse && lat == 2) start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        done_edge = ecnt;
        chk("latency", lat, N);
        chk("busy_cycles", nb, N);
        chk("busy_with_done", busy, 0);
        chk("sum", sum, er);
        chk("carry", carry, ec);
        chk("overflow", overflow, eo);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned de;
        int unsigned de2;
        int          seen;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_carry", carry, 0);
        chk("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(16'd5, 16'd65, 1'b0, 1'b0, 1'b0, de);
        do_op(16'd65535, 16'd1, 1'b0, 1'b0, 1'b0, de);
        do_op(16'd32767, 16'd1, 1'b0, 1'b0, 1'b0, de);
        do_op(16'd32767, 16'd1, 1'b0, 1'b1, 1'b0, de);
        do_op(16'h8000, 16'd1, 1'b1, 1'b1, 1'b0, de);
        do_op(16'd5, 16'd65, 1'b1, 1'b0, 1'b0, de);
        do_op(16'd255, 16'd100, 1'b1, 1'b0, 1'b0, de);
        @(posedge clk); #1;
        @(posedge clk); #1;

        do_op(16'd255, 16'd100, 1'b0, 1'b0, 1'b1, de);
        @(posedge clk); #1;
        chk("single_done", done, 0);
        chk("idle_after_done", busy, 0);
        chk("sum_hold", sum, 355);

        do_op(16'd255, 16'd100, 1'b0, 1'b0, 1'b0, de);
        do_op(16'd1000, 16'd2000, 1'b0, 1'b0, 1'b0, de2);
        chk("b2b_gap", de2 - de, N + 1);

        @(negedge clk);
        in1 = 16'd9; in2 = 16'd9; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", sum, 0);
        chk("abort_carry", carry, 0);
        chk("abort_ovf", overflow, 0);
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("abort_quiet", seen, 0);
        do_op(16'd5, 16'd65, 1'b0, 1'b0, 1'b0, de);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), de);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
